// File: rtl/serdes_pkg.sv
// serdes_pkg: shared FSM encoding, link defaults and width helpers for the F2F serdes pair.
package serdes_pkg;
    localparam logic [1:0] HUNT     = 2'd0;
    localparam logic [1:0] DATA     = 2'd1;
    localparam logic [1:0] SYNC_CHK = 2'd2;

    localparam int          SYNC_W_DEF       = 8;
    localparam logic [7:0]  SYNC_PATTERN_DEF = 8'hA5;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/deserializer_framed_if.sv
// deserializer_framed_if: serial input and parallel word output of the framed deserializer.
interface deserializer_framed_if #(
    parameter int DATA_W = 32
);
    logic              en_i;
    logic              serial_i;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              locked_o;
    logic              sync_err_o;

    modport master(output en_i, serial_i, input data_o, valid_o, locked_o, sync_err_o);
    modport slave(input en_i, serial_i, output data_o, valid_o, locked_o, sync_err_o);
endinterface

// File: rtl/serdes_sync_detect.sv
// serdes_sync_detect: sliding sync window; match/full flag the window the current bit completes.
module serdes_sync_detect
    import serdes_pkg::*;
#(
    parameter int                SYNC_W       = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(SYNC_PATTERN_DEF)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic shift_i,
    input  logic bit_i,
    output logic match_o,
    output logic full_o
);
    localparam int FW = clog2(SYNC_W + 1);

    logic [SYNC_W-1:0] win_q, win_d;
    logic [FW-1:0]     fill_q;

    assign win_d   = {win_q[SYNC_W-2:0], bit_i};
    // Only a window made entirely of sampled bits may match, never cleared-zero padding.
    assign full_o  = shift_i && fill_q >= FW'(SYNC_W - 1);
    assign match_o = full_o && win_d == SYNC_PATTERN;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_q  <= '0;
            fill_q <= '0;
        end else if (clr_i) begin
            win_q  <= '0;
            fill_q <= '0;
        end else if (shift_i) begin
            win_q  <= win_d;
            fill_q <= (fill_q == FW'(SYNC_W)) ? fill_q : fill_q + FW'(1);
        end
    end
endmodule

// File: rtl/deserializer_framed.sv
// deserializer_framed: hunts the sync pattern, assembles payload words and tracks link lock.
module deserializer_framed
    import serdes_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter int                SYNC_W       = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(SYNC_PATTERN_DEF),
    parameter bit                MSB_FIRST    = 1'b1,
    parameter int                MAX_ERR      = 3
) (
    input logic                  clk,
    input logic                  reset,
    deserializer_framed_if.slave bus
);
    localparam int CW = clog2(max2(DATA_W, SYNC_W));

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        err_q, err_d;
    logic [DATA_W-1:0] shreg_q, shreg_d, data_q, data_d;
    logic              valid_q, valid_d, locked_q, locked_d, serr_q, serr_d;
    logic              match, full, clr, shift;

    // The window is reused for the sync check, so it is held empty through DATA.
    assign shift = bus.en_i && state_q != DATA;
    assign clr   = state_q == DATA || (bus.en_i && state_q == SYNC_CHK && full);

    serdes_sync_detect #(
        .SYNC_W      (SYNC_W),
        .SYNC_PATTERN(SYNC_PATTERN)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (clr),
        .shift_i(shift),
        .bit_i  (bus.serial_i),
        .match_o(match),
        .full_o (full)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        locked_d = locked_q;
        valid_d  = 1'b0;
        serr_d   = 1'b0;
        case (state_q)
            HUNT: if (bus.en_i && match) begin
                state_d  = DATA;
                cnt_d    = '0;
                locked_d = 1'b1;
            end
            DATA: if (bus.en_i) begin
                shreg_d = MSB_FIRST ? {shreg_q[DATA_W-2:0], bus.serial_i} : {bus.serial_i, shreg_q[DATA_W-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_W - 1)) begin
                    data_d  = shreg_d;
                    valid_d = 1'b1;
                    state_d = SYNC_CHK;
                    cnt_d   = '0;
                end
            end
            SYNC_CHK: if (bus.en_i) begin
                cnt_d = cnt_q + CW'(1);
                if (full) begin
                    cnt_d   = '0;
                    state_d = DATA;
                    serr_d  = !match;
                    err_d   = match ? '0 : (err_q == 4'hF ? err_q : err_q + 4'd1);
                    if (!match && err_d >= 4'(MAX_ERR)) begin
                        state_d  = HUNT;
                        locked_d = 1'b0;
                        err_d    = '0;
                    end
                end
            end
            default: begin
                state_d  = HUNT;
                cnt_d    = '0;
                locked_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= HUNT;
            cnt_q    <= '0;
            err_q    <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            serr_q   <= serr_d;
        end
    end

    assign bus.data_o     = data_q;
    assign bus.valid_o    = valid_q;
    assign bus.locked_o   = locked_q;
    assign bus.sync_err_o = serr_q;
endmodule

// File: tb/tb_deserializer_framed.sv
// tb_deserializer_framed: directed and randomized framed streams checked against frame-level expectations.
module tb_deserializer_framed;
    logic clk = 1'b0, reset = 1'b0, en = 1'b0, ser = 1'b0;
    always #5 clk = ~clk;

    deserializer_framed_if #(.DATA_W(32)) b0 ();
    deserializer_framed_if #(.DATA_W(16)) b1 ();
    assign b0.en_i = en;
    assign b0.serial_i = ser;
    assign b1.en_i = en;
    assign b1.serial_i = ser;

    deserializer_framed u0 (.clk(clk), .reset(reset), .bus(b0));
    deserializer_framed #(.DATA_W(16), .MSB_FIRST(1'b0)) u1 (.clk(clk), .reset(reset), .bus(b1));

    int checks = 0, failures = 0, nbits = 0, serr_n = 0;
    bit gate = 1'b0;
    logic pv = 1'b0;
    logic [31:0] got_w[$];
    int got_p[$];
    logic [15:0] got1[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb(input logic b);
        en = 1'b1;
        ser = b;
        @(posedge clk);
        #1;
        nbits++;
        if (gate) begin
            en = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendv(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) sb(v[i]);
    endtask

    task automatic sendl(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) sb(v[i]);
    endtask

    task automatic settle();
        en = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic clear();
        got_w.delete();
        got_p.delete();
        got1.delete();
        serr_n = 0;
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (b0.valid_o) begin
            got_w.push_back(b0.data_o);
            got_p.push_back(nbits);
            chk("valid_width", pv, 0);
            chk("valid_and_err", b0.sync_err_o, 0);
        end
        if (b0.sync_err_o) serr_n++;
        if (b1.valid_o) got1.push_back(b1.data_o);
        pv = b0.valid_o;
    end

    initial begin
        logic [31:0] w;
        logic [7:0] s;
        logic [31:0] exp_w[$];
        int exp_p[$];
        int nb0, bad_run, exp_err;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", b0.data_o, 0);
        chk("rst_valid", b0.valid_o, 0);
        chk("rst_locked", b0.locked_o, 0);
        chk("rst_err", b0.sync_err_o, 0);
        reset = 1'b1;

        // lock and receive
        sendv(3'b011, 3);
        sendv(8'h52, 7);
        chk("t1_unlocked", b0.locked_o, 0);
        sb(1'b1);
        chk("t1_locked", b0.locked_o, 1);
        sendv(32'h6F56DF77, 31);
        chk("t1_no_valid_early", b0.valid_o, 0);
        sb(1'b1);
        chk("t1_valid", b0.valid_o, 1);
        chk("t1_data", b0.data_o, 32'hDEADBEEF);
        settle();
        chk("t1_count", got_w.size(), 1);

        // back-to-back frames
        clear();
        sendv(8'hA5, 8); sendv(32'h00000001, 32);
        sendv(8'hA5, 8); sendv(32'h80000000, 32);
        settle();
        chk("t2_count", got_w.size(), 2);
        if (got_w.size() == 2) begin
            chk("t2_w0", got_w[0], 32'h00000001);
            chk("t2_w1", got_w[1], 32'h80000000);
            chk("t2_spacing", got_p[1] - got_p[0], 40);
        end
        chk("t2_err", serr_n, 0);

        // flywheel and loss of lock
        clear();
        sendv(8'hA5, 8); sendv(32'd1, 32);
        sendv(8'h00, 8); sendv(32'd2, 32);
        sendv(8'h00, 8); sendv(32'd3, 32);
        sendv(8'h00, 7);
        chk("t3_still_locked", b0.locked_o, 1);
        sb(1'b0);
        chk("t3_lock_lost", b0.locked_o, 0);
        chk("t3_err_pulse", b0.sync_err_o, 1);
        settle();
        chk("t3_errs", serr_n, 3);
        chk("t3_count", got_w.size(), 3);
        if (got_w.size() == 3) begin
            chk("t3_w2", got_w[1], 32'd2);
            chk("t3_w3", got_w[2], 32'd3);
        end
        sendv(8'hA5, 8);
        chk("t3_relock", b0.locked_o, 1);
        sendv(32'd4, 32);
        settle();
        chk("t3_relock_count", got_w.size(), 4);
        if (got_w.size() == 4) chk("t3_w4", got_w[3], 32'd4);

        // en_i gating
        clear();
        gate = 1'b1;
        sendv(8'hA5, 8); sendv(32'h12345678, 32);
        gate = 1'b0;
        settle();
        chk("t4_count", got_w.size(), 1);
        if (got_w.size() == 1) chk("t4_data", got_w[0], 32'h12345678);

        // asynchronous reset mid-word
        clear();
        sendv(8'hA5, 8);
        sendv(32'hCAFEF00D >> 22, 10);
        #2 reset = 1'b0;
        #1;
        chk("t6_data_clr", b0.data_o, 0);
        chk("t6_locked_clr", b0.locked_o, 0);
        chk("t6_valid_clr", b0.valid_o, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        sendv(32'hCAFEF00D & 32'h003FFFFF, 22);
        settle();
        chk("t6_no_valid", got_w.size(), 0);
        chk("t6_unlocked", b0.locked_o, 0);
        sendv(8'hA5, 8); sendv(32'hCAFEF00D, 32);
        settle();
        chk("t6_count", got_w.size(), 1);
        if (got_w.size() == 1) chk("t6_data", got_w[0], 32'hCAFEF00D);

        // LSB-first, 16-bit payload
        pulse_reset();
        clear();
        sendv(8'hA5, 8);
        sendl(16'h8001, 16);
        settle();
        chk("t5_count", got1.size(), 1);
        if (got1.size() == 1) chk("t5_data", got1[0], 16'h8001);

        // random frames, never three bad syncs in a row so lock is held
        pulse_reset();
        clear();
        nb0 = nbits;
        bad_run = 0;
        exp_err = 0;
        sendv(8'hA5, 8);
        for (int i = 0; i < 24; i++) begin
            gate = ($urandom_range(0, 3) == 0);
            w = $urandom;
            sendv(w, 32);
            exp_w.push_back(w);
            exp_p.push_back(nb0 + 8 + 40 * i + 32);
            s = 8'hA5;
            if (bad_run < 2 && $urandom_range(0, 2) == 0) begin
                s = 8'($urandom);
                if (s == 8'hA5) s = 8'hA4;
                bad_run++;
                exp_err++;
            end else bad_run = 0;
            sendv(s, 8);
        end
        gate = 1'b0;
        settle();
        chk("rnd_count", got_w.size(), exp_w.size());
        if (got_w.size() == exp_w.size())
            for (int i = 0; i < exp_w.size(); i++) begin
                chk($sformatf("rnd_w%0d", i), got_w[i], exp_w[i]);
                chk($sformatf("rnd_p%0d", i), got_p[i], exp_p[i]);
            end
        chk("rnd_errs", serr_n, exp_err);
        chk("rnd_locked", b0.locked_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/deserializer_framed.md
Name: deserializer_framed

Overview:
- Parametrised successor to the fixed 32-bit serial-to-parallel shifter on the F2F LVDS link.
- Receives a continuous single-bit stream. Each frame is a SYNC_W-bit sync pattern followed by a DATA_W-bit payload.
- Hunts for the sync pattern, then assembles payload words and presents each one with a one-cycle valid strobe.
- Tracks link lock: lock is dropped after repeated sync failures.
- Sits between the LVDS input capture and the RX word FIFO.

Parameters:
- DATA_W, 32, payload word width in bits (legal range 2..64).
- SYNC_W, 8, sync pattern width in bits (legal range 2..16).
- SYNC_PATTERN, 8'hA5, expected sync value, SYNC_W bits.
- MSB_FIRST, 1, bit order: 1 = first received payload bit lands in data_o[DATA_W-1]; 0 = it lands in data_o[0].
- MAX_ERR, 3, number of consecutive sync mismatches while locked that forces re-hunt (legal range 1..15).

Ports:
- clk, input, 1, single clock; all state changes on its rising edge.
- reset, input, 1, asynchronous active-low reset.
- en_i, input, 1, bit-enable; serial_i is sampled only on edges where en_i=1.
- serial_i, input, 1, serial data bit.
- data_o, output, DATA_W, last completed payload word.
- valid_o, output, 1, one-cycle pulse when data_o is updated.
- locked_o, output, 1, high while the frame alignment is established.
- sync_err_o, output, 1, one-cycle pulse on each sync mismatch seen while locked.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: data_o=0, valid_o=0, locked_o=0, sync_err_o=0.
  - Internal: state=HUNT; shift register, bit counter and error counter cleared.
  - Applies immediately, including mid-word; any partial word is discarded with no valid_o.
- Sampling:
  - All counters and shift registers advance only on edges with en_i=1.
  - With en_i=0 everything holds, except valid_o and sync_err_o, which deassert.
- HUNT state:
  - Keep a sliding SYNC_W-bit window of sampled bits; the newest bit is the window LSB.
  - When the window equals SYNC_PATTERN (the bit just sampled completes the match) -> go to DATA; bit counter=0; locked_o=1 from that edge.
  - Window matching uses bits sampled in HUNT only.
- DATA state:
  - Shift each sampled bit into the payload register in the order set by MSB_FIRST.
  - On the edge that samples bit DATA_W-1: data_o takes the completed word, valid_o=1 for that one cycle, go to SYNC_CHK, counter=0.
  - Latency: data_o/valid_o are visible the cycle after the last payload bit is sampled.
- SYNC_CHK state:
  - Collect SYNC_W bits.
  - On the edge sampling the last one, compare the collected bits against SYNC_PATTERN:
    - Match: error counter=0, go to DATA.
    - Mismatch: sync_err_o=1 for one cycle, error counter +1. If the counter reaches MAX_ERR -> go to HUNT, locked_o=0, counter=0, window cleared. Otherwise go to DATA (flywheel: alignment is kept).
  - The error counter saturates. It clears only on a match, on re-hunt, or on reset.
- State encoding: HUNT, DATA, SYNC_CHK (2 bits). Illegal encodings -> HUNT.
- data_o holds its value between valid pulses and is not cleared on loss of lock.
- valid_o and sync_err_o are never high in the same cycle.
- Bit counter width is clog2(max(DATA_W, SYNC_W)). Counting wraps only by explicit state-transition reset, never by overflow.

Decomposition:
- Shared package serdes_pkg holds:
  - state encoding constants (HUNT, DATA, SYNC_CHK);
  - default SYNC_PATTERN and SYNC_W;
  - a clog2-style width function.
- The TX-side serializer shares the same package.
- One natural sub-module: serdes_sync_detect. It holds the sliding SYNC_W-bit window and comparator, and outputs match and window-full. It is reused for SYNC_CHK comparison by clearing it at DATA->SYNC_CHK.
- The top level owns the FSM, bit counter, payload shifter and error counter.

Test Plan:
- Lock and receive (default params, en_i=1): 3 garbage bits, then 8'hA5, then 32'hDEADBEEF MSB first -> locked_o rises after the 8th sync bit; valid_o pulses once with data_o=32'hDEADBEEF exactly 1 cycle after the last payload bit.
- Back-to-back frames: A5 / 32'h00000001 / A5 / 32'h80000000 -> two valid pulses exactly 40 sampled bits apart with the correct words; sync_err_o stays 0.
- Flywheel and loss of lock (MAX_ERR=3): after lock, send sync value 8'h00 three times with payloads 1, 2, 3 -> sync_err_o pulses 3 times; words 2 and 3 are still delivered; locked_o drops on the 3rd mismatch; the next A5 relocks.
- en_i gating: toggle en_i 1/0 every cycle during a frame of A5 / 32'h12345678 -> same data_o as the ungated case; valid_o pulse width is 1 cycle.
- MSB_FIRST=0, DATA_W=16: A5 then bits of 16'h8001 sent LSB first -> data_o=16'h8001.
- Reset mid-word: assert reset after 10 payload bits -> outputs cleared asynchronously (before the next clk edge); after release, no valid_o until a fresh A5 plus a full word arrive.
